// File: rtl/sweep_sine_gen.sv
// sweep_sine_gen
// Stepped-chirp sine source. A phase accumulator drives a quarter-wave
// sine LUT. A three-state controller (IDLE/SWEEP/DONE) steps the phase
// increment from a start value to a stop value, holding each step for a
// programmable number of samples.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_start        start pulse, honoured in IDLE only
//   i_abort        return to IDLE, wins over i_start, suppresses o_done
//   i_phase_start  first phase step
//   i_phase_stop   last allowed phase step (inclusive)
//   i_phase_incr   phase-step increment per segment
//   i_dwell        samples per segment (0 behaves as 1)
//   o_data         signed sine sample, 0 when o_valid is low
//   o_valid        o_data carries a sweep sample
//   o_busy         controller is sweeping
//   o_done         one-cycle pulse on normal completion
//   o_phase_step   phase step currently in use
//   o_data_q       cosine sample (only when SWEEP_GEN_QUAD_EN is defined)
//
// Optional feature macro: SWEEP_GEN_QUAD_EN adds the o_data_q cosine output.
//
// Latency: the phase accumulator value of cycle n produces its sample in
// cycle n+3 (address/quadrant, LUT read, sign).

module sweep_sine_gen #(
  parameter int DATA_WIDTH     = 16,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int DWELL_WIDTH    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic        [PHASE_WIDTH-1:0] i_phase_start,
  input  logic        [PHASE_WIDTH-1:0] i_phase_stop,
  input  logic        [PHASE_WIDTH-1:0] i_phase_incr,
  input  logic        [DWELL_WIDTH-1:0] i_dwell,
  output logic signed [DATA_WIDTH-1:0]  o_data,
  output logic                          o_valid,
  output logic                          o_busy,
  output logic                          o_done,
  output logic        [PHASE_WIDTH-1:0] o_phase_step
`ifdef SWEEP_GEN_QUAD_EN
  ,
  output logic signed [DATA_WIDTH-1:0]  o_data_q
`endif
);

  localparam int  LUT_DEPTH = 1 << LUT_ADDR_WIDTH;
  localparam real PI        = 3.14159265358979323846;

  // Positive quarter-wave entry, sampled at the bucket centre and rounded.
  function automatic logic signed [DATA_WIDTH-1:0] lut_entry(input int k);
    real amp;
    real ang;
    amp = real'((1 << (DATA_WIDTH - 1)) - 1);
    ang = 2.0 * PI * (real'(k) + 0.5) / real'(4 * LUT_DEPTH);
    return DATA_WIDTH'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  // Entries never reach -2^(DATA_WIDTH-1), so negation cannot overflow.
  function automatic logic signed [DATA_WIDTH-1:0] apply_sign(
    input logic signed [DATA_WIDTH-1:0] mag,
    input logic                         neg
  );
    return neg ? -mag : mag;
  endfunction

  logic signed [DATA_WIDTH-1:0] lut [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam logic signed [DATA_WIDTH-1:0] ENTRY = lut_entry(k);
    assign lut[k] = ENTRY;
  end

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [PHASE_WIDTH-1:0]   phase_step_q, phase_step_d;
  logic [PHASE_WIDTH-1:0]   phase_acc_q, phase_acc_d;
  logic [PHASE_WIDTH-1:0]   stop_q, stop_d;
  logic [PHASE_WIDTH-1:0]   incr_q, incr_d;
  logic [DWELL_WIDTH-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_WIDTH-1:0]   dwell_m1_q, dwell_m1_d;
  logic [PHASE_WIDTH:0]     step_next;

  // Sweep controller
  always_comb begin
    state_d      = state_q;
    phase_step_d = phase_step_q;
    phase_acc_d  = phase_acc_q;
    stop_d       = stop_q;
    incr_d       = incr_q;
    dwell_cnt_d  = dwell_cnt_q;
    dwell_m1_d   = dwell_m1_q;
    // One extra bit so a wrap past the top of the phase range is detected.
    step_next    = {1'b0, phase_step_q} + {1'b0, incr_q};

    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          phase_step_d = i_phase_start;
          phase_acc_d  = '0;
          stop_d       = i_phase_stop;
          incr_d       = i_phase_incr;
          dwell_cnt_d  = '0;
          dwell_m1_d   = (i_dwell == '0) ? '0 : i_dwell - DWELL_WIDTH'(1);
          state_d      = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else begin
          phase_acc_d = phase_acc_q + phase_step_q;
          if (dwell_cnt_q == dwell_m1_q) begin
            dwell_cnt_d = '0;
            if ((incr_q == '0) || step_next[PHASE_WIDTH] ||
                (step_next[PHASE_WIDTH-1:0] > stop_q)) begin
              state_d = S_DONE;
            end else begin
              phase_step_d = step_next[PHASE_WIDTH-1:0];
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output pipeline signals
  logic [1:0]                   quad_s;
  logic [LUT_ADDR_WIDTH-1:0]    addr_s;
  logic                         vld_p0_q, vld_p0_d;
  logic                         vld_p1_q, vld_p1_d;
  logic                         vld_p2_q, vld_p2_d;
  logic [LUT_ADDR_WIDTH-1:0]    addr_p0_q, addr_p0_d;
  logic                         neg_p0_q, neg_p0_d;
  logic signed [DATA_WIDTH-1:0] mag_p1_q, mag_p1_d;
  logic                         neg_p1_q, neg_p1_d;
  logic signed [DATA_WIDTH-1:0] data_p2_q, data_p2_d;

  always_comb begin
    quad_s = phase_acc_q[PHASE_WIDTH-1 -: 2];
    addr_s = phase_acc_q[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
    // Stage p0: quadrant fold (odd quadrants run the table backwards)
    vld_p0_d  = (state_q == S_SWEEP);
    addr_p0_d = quad_s[0] ? ~addr_s : addr_s;
    neg_p0_d  = quad_s[1];
    // Stage p1: LUT read
    vld_p1_d  = vld_p0_q;
    mag_p1_d  = lut[addr_p0_q];
    neg_p1_d  = neg_p0_q;
    // Stage p2: sign
    vld_p2_d  = vld_p1_q;
    data_p2_d = apply_sign(mag_p1_q, neg_p1_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      phase_step_q <= '0;
      dwell_cnt_q  <= '0;
      vld_p0_q     <= 1'b0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_step_q <= phase_step_d;
      dwell_cnt_q  <= dwell_cnt_d;
      vld_p0_q     <= vld_p0_d;
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
    end
  end

  // Datapath registers carry no reset; the valid chain qualifies them.
  always_ff @(posedge i_clk) begin
    phase_acc_q <= phase_acc_d;
    stop_q      <= stop_d;
    incr_q      <= incr_d;
    dwell_m1_q  <= dwell_m1_d;
    addr_p0_q   <= addr_p0_d;
    neg_p0_q    <= neg_p0_d;
    mag_p1_q    <= mag_p1_d;
    neg_p1_q    <= neg_p1_d;
    data_p2_q   <= data_p2_d;
  end

`ifdef SWEEP_GEN_QUAD_EN
  // Cosine path: a quarter turn ahead only changes the quadrant bits.
  logic [1:0]                   quad_c_s;
  logic [LUT_ADDR_WIDTH-1:0]    addr_c_p0_q, addr_c_p0_d;
  logic                         neg_c_p0_q, neg_c_p0_d;
  logic signed [DATA_WIDTH-1:0] mag_c_p1_q, mag_c_p1_d;
  logic                         neg_c_p1_q, neg_c_p1_d;
  logic signed [DATA_WIDTH-1:0] data_c_p2_q, data_c_p2_d;

  always_comb begin
    quad_c_s    = phase_acc_q[PHASE_WIDTH-1 -: 2] + 2'd1;
    // Stage p0
    addr_c_p0_d = quad_c_s[0] ? ~phase_acc_q[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH]
                              :  phase_acc_q[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
    neg_c_p0_d  = quad_c_s[1];
    // Stage p1
    mag_c_p1_d  = lut[addr_c_p0_q];
    neg_c_p1_d  = neg_c_p0_q;
    // Stage p2
    data_c_p2_d = apply_sign(mag_c_p1_q, neg_c_p1_q);
  end

  always_ff @(posedge i_clk) begin
    addr_c_p0_q <= addr_c_p0_d;
    neg_c_p0_q  <= neg_c_p0_d;
    mag_c_p1_q  <= mag_c_p1_d;
    neg_c_p1_q  <= neg_c_p1_d;
    data_c_p2_q <= data_c_p2_d;
  end

  assign o_data_q = vld_p2_q ? data_c_p2_q : '0;
`else
  // Single-channel build: no cosine path.
`endif

  assign o_data       = vld_p2_q ? data_p2_q : '0;
  assign o_valid      = vld_p2_q;
  assign o_busy       = (state_q == S_SWEEP);
  assign o_done       = (state_q == S_DONE) && !i_abort;
  assign o_phase_step = phase_step_q;

endmodule

// File: tb/tb_sweep_sine_gen.sv
module tb_sweep_sine_gen;
  localparam real PI = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst, st, ab;
  logic        [31:0] p_start, p_stop, p_incr;
  logic        [15:0] dwell;
  logic signed [15:0] o_data;
  logic               o_valid, o_busy, o_done;
  logic        [31:0] o_phase_step;
`ifdef SWEEP_GEN_QUAD_EN
  logic signed [15:0] o_data_q;
`endif

  always #5 clk = ~clk;

  sweep_sine_gen #(
    .DATA_WIDTH(16), .PHASE_WIDTH(32), .LUT_ADDR_WIDTH(8), .DWELL_WIDTH(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(st), .i_abort(ab),
    .i_phase_start(p_start), .i_phase_stop(p_stop), .i_phase_incr(p_incr),
    .i_dwell(dwell), .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy),
    .o_done(o_done), .o_phase_step(o_phase_step)
`ifdef SWEEP_GEN_QUAD_EN
    , .o_data_q(o_data_q)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_ph[$];
  logic [31:0] exp_step[$];
  int          got[$];
  int          gotq[$];
  logic [31:0] steps_seen[$];
  int          n_valid, n_done;
  bit          chk_en = 1'b0;
  bit          h1 = 1'b0, h2 = 1'b0, h3 = 1'b0, prev_busy = 1'b0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Ideal sine at the centre of the 1/1024-turn bucket holding the phase,
  // scaled by 32767 and rounded half away from zero.
  function automatic int ideal(input logic [31:0] ph, input int quarter);
    int  p;
    real v;
    p = (int'(ph[31:22]) + 256 * quarter) % 1024;
    v = 32767.0 * $sin(2.0 * PI * (real'(p) + 0.5) / 1024.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  // Whole-sweep model: one entry per sample for phase and phase step.
  task automatic build(input logic [31:0] s0, input logic [31:0] inc,
                       input logic [31:0] stp, input logic [15:0] dw);
    logic [31:0] s;
    logic [31:0] acc;
    logic [32:0] nx;
    int          d;
    s   = s0;
    acc = 32'd0;
    d   = (dw == 16'd0) ? 1 : int'(dw);
    while (1) begin
      for (int i = 0; i < d; i++) begin
        exp_ph.push_back(acc);
        exp_step.push_back(s);
        acc = acc + s;
      end
      nx = {1'b0, s} + {1'b0, inc};
      if (inc == 32'd0 || nx[32] || nx[31:0] > stp) break;
      s = nx[31:0];
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] ph;
    logic [31:0] es;
    int          e;
    if (chk_en) begin
      chk(o_valid == h3, "valid_align", longint'(o_valid), longint'(h3));
      if (o_valid) begin
        n_valid++;
        got.push_back(int'(o_data));
        if (exp_ph.size() == 0) begin
          chk(1'b0, "extra_sample", longint'(o_data), 0);
        end else begin
          ph = exp_ph.pop_front();
          e  = ideal(ph, 0);
          chk((int'(o_data) - e) >= -1 && (int'(o_data) - e) <= 1, "sine_sample",
              longint'(o_data), longint'(e));
`ifdef SWEEP_GEN_QUAD_EN
          gotq.push_back(int'(o_data_q));
          e = ideal(ph, 1);
          chk((int'(o_data_q) - e) >= -1 && (int'(o_data_q) - e) <= 1, "cos_sample",
              longint'(o_data_q), longint'(e));
`endif
        end
      end else begin
        chk(o_data == 16'sd0, "data_idle_zero", longint'(o_data), 0);
`ifdef SWEEP_GEN_QUAD_EN
        chk(o_data_q == 16'sd0, "cos_idle_zero", longint'(o_data_q), 0);
`endif
      end
      if (o_busy) begin
        if (steps_seen.size() == 0 || steps_seen[$] != o_phase_step)
          steps_seen.push_back(o_phase_step);
        if (exp_step.size() == 0) begin
          chk(1'b0, "extra_busy_cycle", longint'(o_phase_step), 0);
        end else begin
          es = exp_step.pop_front();
          chk(o_phase_step == es, "phase_step", longint'(o_phase_step), longint'(es));
        end
      end
      if (o_done) begin
        n_done++;
        chk(prev_busy && !o_busy, "done_timing", longint'({prev_busy, o_busy}), 2);
      end
      h3 = h2;
      h2 = h1;
      h1 = o_busy;
      prev_busy = o_busy;
      if (rst) begin
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0; prev_busy = 1'b0;
        exp_ph.delete();
        exp_step.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [31:0] s0, input logic [31:0] inc,
                             input logic [31:0] stp, input logic [15:0] dw);
    n_valid = 0;
    n_done  = 0;
    got.delete();
    gotq.delete();
    steps_seen.delete();
    build(s0, inc, stp, dw);
    p_start = s0;
    p_incr  = inc;
    p_stop  = stp;
    dwell   = dw;
    st      = 1'b1;
    tick();
    st      = 1'b0;
    chk(o_busy == 1'b1, "busy_rise", longint'(o_busy), 1);
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (o_busy && c < budget) begin
      tick();
      c++;
    end
    chk(!o_busy, "sweep_timeout", c, budget);
    repeat (5) tick();
  endtask

  task automatic check_sweep(input string name, input int samples, input int segs);
    chk(n_valid == samples, {name, "_samples"}, n_valid, samples);
    chk(n_done == 1, {name, "_done_count"}, n_done, 1);
    chk(steps_seen.size() == segs, {name, "_segments"}, steps_seen.size(), segs);
    chk(exp_ph.size() == 0, {name, "_samples_missing"}, exp_ph.size(), 0);
  endtask

  initial begin
    int mx, mn;
    rst = 1'b1; st = 1'b0; ab = 1'b0;
    p_start = '0; p_stop = '0; p_incr = '0; dwell = '0;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk(o_data == 16'sd0, "rst_data", longint'(o_data), 0);
    chk(o_valid == 1'b0, "rst_valid", longint'(o_valid), 0);
    chk(o_busy == 1'b0, "rst_busy", longint'(o_busy), 0);
    chk(o_done == 1'b0, "rst_done", longint'(o_done), 0);
    chk(o_phase_step == 32'd0, "rst_step", longint'(o_phase_step), 0);

    // Basic sweep with a stray start pulse mid-sweep
    start_sweep(32'h0010_0000, 32'h0010_0000, 32'h0040_0000, 16'd500);
    chk(exp_ph.size() == 2000, "model_len", exp_ph.size(), 2000);
    repeat (300) tick();
    p_start = 32'h0800_0000;
    st = 1'b1;
    tick();
    st = 1'b0;
    chk(o_busy == 1'b1, "start_ignored", longint'(o_busy), 1);
    wait_done(3000);
    check_sweep("basic", 2000, 4);
    if (steps_seen.size() == 4) begin
      chk(steps_seen[0] == 32'h0010_0000, "seg0", longint'(steps_seen[0]), 32'h0010_0000);
      chk(steps_seen[1] == 32'h0020_0000, "seg1", longint'(steps_seen[1]), 32'h0020_0000);
      chk(steps_seen[2] == 32'h0030_0000, "seg2", longint'(steps_seen[2]), 32'h0030_0000);
      chk(steps_seen[3] == 32'h0040_0000, "seg3", longint'(steps_seen[3]), 32'h0040_0000);
    end

    // Waveform accuracy: 16 samples per period
    start_sweep(32'h1000_0000, 32'h0, 32'h1000_0000, 16'd64);
    wait_done(200);
    check_sweep("wave", 64, 1);
    if (got.size() == 64) begin
      chk(got[0] == 101, "wave_s0", got[0], 101);
      chk(got[4] == 32767, "wave_peak", got[4], 32767);
      chk(got[8] == -101, "wave_s8", got[8], -101);
      chk(got[12] == -32767, "wave_neg_peak", got[12], -32767);
      mx = -40000; mn = 40000;
      foreach (got[i]) begin
        if (got[i] > mx) mx = got[i];
        if (got[i] < mn) mn = got[i];
      end
      chk(mx == 32767, "wave_max", mx, 32767);
      chk(mn == -32767, "wave_min", mn, -32767);
    end

    // Edge cases
    start_sweep(32'hFFF0_0000, 32'h0010_0000, 32'hFFFF_FFFF, 16'd8);
    wait_done(100);
    check_sweep("carry", 8, 1);
    start_sweep(32'h0100_0000, 32'h0, 32'hFFFF_FFFF, 16'd5);
    wait_done(100);
    check_sweep("incr0", 5, 1);
    start_sweep(32'h0200_0000, 32'h0010_0000, 32'h0100_0000, 16'd3);
    wait_done(100);
    check_sweep("start_gt_stop", 3, 1);
    start_sweep(32'h1000_0000, 32'h1000_0000, 32'h3000_0000, 16'd0);
    wait_done(100);
    check_sweep("dwell0", 3, 3);

    // Abort in busy cycle 100
    start_sweep(32'h0100_0000, 32'h0100_0000, 32'h0800_0000, 16'd50);
    repeat (100) tick();
    ab = 1'b1;
    tick();
    ab = 1'b0;
    chk(o_busy == 1'b0, "abort_busy", longint'(o_busy), 0);
    tick();
    chk(o_valid == 1'b1, "abort_drain1", longint'(o_valid), 1);
    tick();
    chk(o_valid == 1'b1, "abort_drain2", longint'(o_valid), 1);
    tick();
    chk(o_valid == 1'b0, "abort_valid_low", longint'(o_valid), 0);
    repeat (3) tick();
    chk(n_valid == 101, "abort_samples", n_valid, 101);
    chk(n_done == 0, "abort_no_done", n_done, 0);
    exp_ph.delete();
    exp_step.delete();

    // Start and abort together in IDLE
    n_valid = 0;
    st = 1'b1; ab = 1'b1;
    tick();
    st = 1'b0; ab = 1'b0;
    chk(o_busy == 1'b0, "start_abort_idle", longint'(o_busy), 0);
    repeat (4) tick();
    chk(n_valid == 0, "start_abort_nosamples", n_valid, 0);

    // Reset held 4 cycles mid-sweep
    start_sweep(32'h0010_0000, 32'h0010_0000, 32'h0040_0000, 16'd500);
    repeat (50) tick();
    rst = 1'b1;
    repeat (4) tick();
    chk(o_data == 16'sd0, "midrst_data", longint'(o_data), 0);
    chk(o_valid == 1'b0, "midrst_valid", longint'(o_valid), 0);
    chk(o_busy == 1'b0, "midrst_busy", longint'(o_busy), 0);
    chk(o_phase_step == 32'd0, "midrst_step", longint'(o_phase_step), 0);
    rst = 1'b0;
    repeat (5) tick();
    chk(n_done == 0, "midrst_no_done", n_done, 0);
    chk(o_busy == 1'b0, "midrst_idle", longint'(o_busy), 0);

`ifdef SWEEP_GEN_QUAD_EN
    start_sweep(32'h0400_0000, 32'h0, 32'h0400_0000, 16'd64);
    wait_done(200);
    check_sweep("quad", 64, 1);
    if (gotq.size() == 64) chk(gotq[0] == 32767, "quad_cos0", gotq[0], 32767);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
